// File: rtl/tx.sv
// Serial transmitter: valid/ready byte in; start, 8 data bits LSB first, optional parity, stop out.
// Define TX_HOLD_BUF_EN to add a one-entry holding register so frames can run back to back.
module tx #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_par_en,
    input  logic       i_par_typ,
    input  logic [5:0] i_prescale,
    output logic       o_tx_out,
    output logic       o_busy,
    output logic       o_done_flag
);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e        state_q, state_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [7:0]    data_q, data_d;
    logic          par_en_q, par_en_d;
    logic          par_typ_q, par_typ_d;
    logic [5:0]    ps_q, ps_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [5:0]    btick_q, btick_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    idx_nxt;

    logic          accept;
    logic          tick_end;
    logic          bit_end;
    logic          frame_slot;
    logic          load;
    logic [7:0]    load_byte;

`ifdef TX_HOLD_BUF_EN
    logic [7:0]    buf_q, buf_d;
    logic          buf_full_q, buf_full_d;
    logic          buf_take;
    logic          direct;

    assign o_ready = ~buf_full_q;
`else
    assign o_ready = (state_q == StIdle);
`endif

    assign accept     = i_valid & o_ready;
    assign tick_end   = (tick_q == TickMax);
    assign bit_end    = tick_end && (btick_q == ps_q - 6'd1);
    assign idx_nxt    = idx_q + 3'd1;
    // A new frame may begin from IDLE or directly out of a completing stop bit.
    assign frame_slot = (state_q == StIdle) || ((state_q == StStop) && bit_end);

`ifdef TX_HOLD_BUF_EN
    assign buf_take  = buf_full_q && frame_slot;
    assign direct    = accept && frame_slot;
    assign load      = buf_take || direct;
    assign load_byte = buf_full_q ? buf_q : i_data;
`else
    assign load      = accept;
    assign load_byte = i_data;
`endif

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        ps_d      = ps_q;
        tick_d    = tick_q;
        btick_d   = btick_q;
        idx_d     = idx_q;
`ifdef TX_HOLD_BUF_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (buf_take) begin
            buf_full_d = 1'b0;
        end
        if (accept && !direct) begin
            buf_d      = i_data;
            buf_full_d = 1'b1;
        end
`endif

        if (state_q != StIdle) begin
            if (tick_end) begin
                tick_d  = '0;
                btick_d = bit_end ? 6'd0 : btick_q + 6'd1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = (^data_q) ^ par_typ_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Frame parameters are captured here so mid-frame input changes are ignored.
        if (load) begin
            state_d   = StStart;
            tx_d      = 1'b0;
            data_d    = load_byte;
            par_en_d  = i_par_en;
            par_typ_d = i_par_typ;
            ps_d      = (i_prescale == 6'd0) ? 6'd1 : i_prescale;
            tick_d    = '0;
            btick_d   = 6'd0;
            idx_d     = 3'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            data_q    <= 8'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            ps_q      <= 6'd1;
            tick_q    <= '0;
            btick_q   <= 6'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            ps_q      <= ps_d;
            tick_q    <= tick_d;
            btick_q   <= btick_d;
            idx_q     <= idx_d;
        end
    end

`ifdef TX_HOLD_BUF_EN
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            buf_q      <= 8'd0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign o_tx_out    = tx_q;
    assign o_busy      = (state_q != StIdle);
    assign o_done_flag = done_q;

endmodule

// File: tb/tb_tx.sv
// Scoreboard bench for tx: stimulus queues expected frames, a monitor decodes the serial line.
module tb_tx;
    localparam int TD = 1;
`ifdef TX_HOLD_BUF_EN
    localparam int BUF = 1;
`else
    localparam int BUF = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_par_en;
    logic       i_par_typ;
    logic [5:0] i_prescale;
    logic       o_tx_out;
    logic       o_busy;
    logic       o_done_flag;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        int         per;
        logic       b2b;
        logic       abort;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    tx #(.TICK_DIV(TD)) dut (
        .i_clk      (clk),
        .i_arst_n   (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_par_en   (i_par_en),
        .i_par_typ  (i_par_typ),
        .i_prescale (i_prescale),
        .o_tx_out   (o_tx_out),
        .o_busy     (o_busy),
        .o_done_flag(o_done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (o_done_flag === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the handshake edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                        input logic pbit, input logic b2b, input logic ab, output int waited);
        exp_t e;
        i_data     = d;
        i_par_en   = pe;
        i_par_typ  = pt;
        i_prescale = ps;
        i_valid    = 1'b1;
        waited     = 0;
        while (!o_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", o_ready, 1);
        if (!o_ready) begin
            i_valid = 1'b0;
            return;
        end
        e.data    = d;
        e.par_en  = pe;
        e.par_bit = pbit;
        e.per     = ((ps == 6'd0) ? 1 : int'(ps)) * TD;
        e.b2b     = b2b;
        e.abort   = ab;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cyc, output int rdy_cyc);
        busy_cyc = 0;
        rdy_cyc  = 0;
        while (o_busy && busy_cyc < 5000) begin
            busy_cyc++;
            if (o_ready) rdy_cyc++;
            @(negedge clk);
        end
        check("idle_reached", o_busy, 0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic        have_start;
        logic        ok;
        logic        aborted;
        logic [10:0] fr;
        int          nb;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                while (!rst_n || o_tx_out) @(negedge clk);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
                have_start = 1'b0;
                while (rst_n && !o_tx_out) @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            check($sformatf("start_gap_%02h", e.data), have_start, e.b2b);
            check($sformatf("busy_at_start_%02h", e.data), o_busy, 1);
            fr = {1'b1, 1'b1, e.data, 1'b0};
            nb = 10;
            if (e.par_en) begin
                fr = {1'b1, e.par_bit, e.data, 1'b0};
                nb = 11;
            end
            aborted = 1'b0;
            for (int b = 0; b < nb && !aborted; b++) begin
                ok = 1'b1;
                for (int s = 0; s < e.per; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (o_tx_out !== fr[b]) ok = 1'b0;
                end
                if (!aborted) check($sformatf("bit%0d_of_%02h", b, e.data), ok, 1);
            end
            check($sformatf("abort_%02h", e.data), aborted, e.abort);
            if (aborted) begin
                have_start = 1'b0;
                continue;
            end
            @(negedge clk);
            check($sformatf("done_after_%02h", e.data), o_done_flag, 1);
            have_start = rst_n && !o_tx_out;
        end
    end

    initial begin : stim
        int w, b, r, n, bad_tx, bad_rdy, bad_busy, bad_done;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_data     = 8'h00;
        i_par_en   = 1'b0;
        i_par_typ  = 1'b0;
        i_prescale = 6'd8;
        repeat (3) @(negedge clk);
        check("rst_tx", o_tx_out, 1);
        check("rst_ready", o_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done_flag, 0);
        rst_n = 1'b1;
        bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_tx_out !== 1'b1) bad_tx++;
            if (o_ready !== 1'b1) bad_rdy++;
            if (o_busy !== 1'b0) bad_busy++;
            if (o_done_flag !== 1'b0) bad_done++;
        end
        check("idle50_tx_low_cycles", bad_tx, 0);
        check("idle50_ready_low_cycles", bad_rdy, 0);
        check("idle50_busy_cycles", bad_busy, 0);
        check("idle50_done_cycles", bad_done, 0);

        // 0xA5, even parity: parity bit 0, 88 cycles.
        send(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, w);
        wait_idle(b, r);
        check("a5_busy_cycles", b, 88);
        check("a5_ready_in_frame", r, (BUF != 0) ? 88 : 0);

        // 0x00, odd parity: parity bit 1.
        send(8'h00, 1'b1, 1'b1, 6'd8, 1'b1, 1'b0, 1'b0, w);
        wait_idle(b, r);
        check("00_busy_cycles", b, 88);

        // 0xFF, no parity: 80 cycles.
        send(8'hFF, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, w);
        wait_idle(b, r);
        check("ff_busy_cycles", b, 80);

        // Back to back with i_valid held: 0x55 then 0x0F, 4 ticks per bit.
        send(8'h55, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, w);
        send(8'h0F, 1'b1, 1'b0, 6'd4, 1'b0, (BUF != 0), 1'b0, w);
        check("b2b_accept_wait", w, (BUF != 0) ? 0 : 44);
        n = 0;
        while (!o_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("b2b_ready_low_cycles", n, (BUF != 0) ? 43 : 44);
        wait_idle(b, r);
        check("b2b_tail_busy", b, (BUF != 0) ? 44 : 0);

        // Mid-frame changes to prescale and parity type are ignored.
        send(8'hC3, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, w);
        repeat (23) @(negedge clk);
        i_prescale = 6'd4;
        i_par_typ  = 1'b1;
        wait_idle(b, r);
        check("c3_busy_remaining", b, 65);
        send(8'h81, 1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0, w);
        wait_idle(b, r);
        check("81_busy_cycles", b, 44);

        // Prescale 0 behaves as 1.
        send(8'h5A, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, w);
        wait_idle(b, r);
        check("5a_busy_cycles", b, 10);

        // Asynchronous reset in the middle of DATA.
        send(8'h99, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 1'b1, w);
        repeat (29) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx", o_tx_out, 1);
        check("arst_busy", o_busy, 0);
        check("arst_ready", o_ready, 1);
        check("arst_done", o_done_flag, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", o_tx_out, 1);
        check("post_rst_busy", o_busy, 0);
        send(8'h3C, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, w);
        wait_idle(b, r);
        check("3c_busy_cycles", b, 88);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx.md
# tx

Serial transmitter paired with the `rx` block of this codebase. It accepts bytes over a valid/ready handshake and serializes each as one frame on `o_tx_out`: start bit, 8 data bits LSB first, an optional parity bit and a stop bit. It uses the same `i_par_en`, `i_par_typ` and `i_prescale` conventions as the receiver, so a `tx` → `rx` loopback works with identical settings.

## Interface
- `TICK_DIV`, default 1: `i_clk` cycles per oversample tick (≥1).
- `i_clk`  in  1  system clock. One clock domain; all logic is rising-edge.
- `i_arst_n`  in  1  reset, asynchronous, active-low.
- `i_data`  in  8  byte to send.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  byte accepted on a cycle where `i_valid & o_ready`.
- `i_par_en`  in  1  1 = insert a parity bit.
- `i_par_typ`  in  1  0 = even parity, 1 = odd parity.
- `i_prescale`  in  6  ticks per serial bit. A value of 0 is treated as 1.
- `o_tx_out`  out  1  serial line; idles high.
- `o_busy`  out  1  a frame is in progress.
- `o_done_flag`  out  1  one-cycle pulse when a stop bit completes.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE → START:** on an accepted byte, or on a byte held in the buffer.
- **Sampling at START entry:** the block latches the shift register, `i_par_en`, `i_par_typ` and `i_prescale`. Changes to these inputs mid-frame have no effect.
- **START:** drive 0 for one bit period.
- **DATA:** drive 8 bits LSB first. A 3-bit index counts 0..7.
- **PARITY:** entered only if the latched `par_en` = 1. Drive `^data ^ par_typ`.
- **STOP:** drive 1 for one bit period, then pulse `o_done_flag`.
  - If the buffer is full, go directly to START with the buffered byte.
  - Otherwise go to IDLE.
- **Bit period:** latched prescale × `TICK_DIV` `i_clk` cycles.
  - A tick counter counts 0..`TICK_DIV`−1.
  - A per-bit tick counter counts 0..prescale−1 (6 bits). It wraps on each bit boundary.
- **Frame length:** 10 bit periods with parity disabled, 11 with parity enabled.
- **`o_tx_out`** is registered, with no combinational path from any input.
- **`o_busy`** = 1 in every state other than IDLE.
- **`o_ready`:** see Configuration.
- **Simultaneous events:** a byte accepted on the same cycle that STOP completes follows the rules for the buffered and unbuffered builds. No byte is ever lost or duplicated.
- **Reset (asserted at any time, including mid-frame):** state IDLE, `o_tx_out`=1, `o_busy`=0, `o_done_flag`=0, `o_ready`=1, buffer empty, all counters 0. A partial frame is abandoned; the line returns high immediately.

## Timing
- Acceptance at edge N: `o_tx_out` falls to 0 at edge N+1, and `o_busy` rises at N+1.
- Each bit lasts exactly prescale×`TICK_DIV` cycles, measured from edge to edge of `o_tx_out`.
- `o_done_flag` is high for the single cycle following the last STOP cycle.
- In an unbuffered back-to-back case, the earliest next acceptance is the cycle after `o_done_flag`. `o_tx_out` then stays at 1 for at least one idle cycle.
- With the buffer, the next start bit directly follows the stop bit (zero idle cycles). `o_done_flag` pulses on the first START cycle.

## Configuration
- **`TX_HOLD_BUF_EN` defined:** the block has a one-entry holding register.
  - `o_ready` = buffer empty. A byte may be accepted while a frame is in progress.
  - The buffered byte starts on the cycle after its predecessor's STOP ends.
  - In IDLE, an accepted byte goes straight to the shift register, and `o_ready` stays 1.
- **`TX_HOLD_BUF_EN` undefined:** no buffer.
  - `o_ready` = (state == IDLE).
  - A byte is only accepted in IDLE.

## Test plan
- Reset release with `i_valid`=0 for 50 cycles → `o_tx_out`=1, `o_ready`=1, `o_busy`=0, `o_done_flag` never pulses.
- `TICK_DIV`=1, prescale=8, `par_en`=1, `par_typ`=0, data 0xA5.
  - `o_tx_out` sequence: 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each held 8 cycles (88 cycles total).
  - `o_done_flag` pulses at cycle 89 after acceptance.
- Odd parity, data 0x00 → parity bit 1. `par_en`=0, data 0xFF → 80-cycle frame with no parity bit.
- Buffered build: send 0x55 then 0x0F, with `i_valid` held high → second start bit immediately follows the first stop bit, `o_ready` deasserts while the buffer is full, two `o_done_flag` pulses. Unbuffered build → `o_ready`=0 throughout the first frame.
- Change `i_prescale` from 8 to 4 and toggle `i_par_typ` during the DATA state → current frame is unaffected; the next frame uses 4 ticks per bit.
- Assert `i_arst_n`=0 in the middle of DATA → `o_tx_out` returns to 1 asynchronously. After release, a new byte 0x3C transmits correctly from its start bit.
